// File: rtl/hfrv_trace_pkg.sv
// Shared types and constants for the HF-RISCV retired-instruction trace monitor.
package hfrv_trace_pkg;

  localparam int TRACE_XLEN = 32;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic [TRACE_XLEN-1:0] daddr;
    logic                  dwe;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } trace_state_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Major opcode class: inst[1:0] is always 2'b11 for 32-bit encodings.
  function automatic logic [4:0] op_class(input logic [31:0] inst);
    return inst[6:2];
  endfunction

endpackage

// File: rtl/hfrv_trace_fifo.sv
// Circular trace storage with FWFT head, entry count and overwrite-oldest on full.
module hfrv_trace_fifo
  import hfrv_trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  trace_entry_t wdata_i,
  output trace_entry_t head_o,
  output logic [PTR_W:0] count_o,
  output logic [PTR_W:0] count_next_o,
  output logic         full_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  trace_entry_t     mem_q [DEPTH];
  trace_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_pop;

  assign full_o       = (count_q == FULL_CNT);
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

  // A push into a full buffer advances the read pointer too, either because the
  // head is popped this cycle or because the oldest entry is being overwritten.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop || (push_i && full_o)) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_i && !do_pop && !full_o) begin
        count_d = count_q + 1'b1;
      end else if (do_pop && !push_i) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hfrv_trace_monitor.sv
// Retired-instruction trace monitor: capture FSM, opcode filter, class counters
// and drop statistics around a circular trace buffer.
module hfrv_trace_monitor
  import hfrv_trace_pkg::*;
#(
  parameter  int XLEN  = TRACE_XLEN,
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             snap_valid_i,
  input  logic [XLEN-1:0]  snap_pc_i,
  input  logic [31:0]      snap_inst_i,
  input  logic [XLEN-1:0]  snap_daddr_i,
  input  logic             snap_dwe_i,
  input  logic             arm_i,
  input  logic             stop_i,
  input  logic             mode_wrap_i,
  input  logic             filter_en_i,
  input  logic [6:0]       filter_opcode_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [XLEN-1:0]  rd_pc_o,
  output logic [31:0]      rd_inst_o,
  output logic [XLEN-1:0]  rd_daddr_o,
  output logic             rd_dwe_o,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] dropped_o,
  output logic [1:0]       state_o,
  input  logic [4:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  trace_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [CNT_W-1:0] dropped_q, dropped_d;
  logic             overflow_q, overflow_d;

  trace_entry_t   wdata, head;
  logic [PTR_W:0] fifo_count, fifo_count_next;
  logic           fifo_full;
  logic           candidate, accept, pop_eff, lose_full, push, overwrite, drop;
  logic [4:0]     cls;

  assign wdata = '{pc: snap_pc_i, inst: snap_inst_i, daddr: snap_daddr_i, dwe: snap_dwe_i};
  assign cls   = op_class(snap_inst_i);

  hfrv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (arm_i),
    .push_i       (push),
    .pop_i        (rd_ready_i),
    .wdata_i      (wdata),
    .head_o       (head),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next),
    .full_o       (fifo_full)
  );

  // A full buffer in freeze mode can still see an accept if wrap mode was
  // dropped mid-capture; that snapshot is lost instead of overwriting.
  always_comb begin
    candidate = snap_valid_i && !arm_i &&
                (!filter_en_i || (snap_inst_i[6:0] == filter_opcode_i));
    accept    = candidate && (state_q == CAPTURE);
    pop_eff   = rd_ready_i && (fifo_count != '0);
    lose_full = accept && fifo_full && !pop_eff && !mode_wrap_i;
    push      = accept && !lose_full;
    overwrite = push && fifo_full && !pop_eff;
    drop      = lose_full || overwrite || (candidate && (state_q == FROZEN));
  end

  always_comb begin
    state_d = state_q;
    if (arm_i) begin
      state_d = CAPTURE;
    end else if (stop_i) begin
      state_d = IDLE;
    end else if ((state_q == CAPTURE) && !mode_wrap_i &&
                 (lose_full || (push && (fifo_count_next == FULL_CNT)))) begin
      state_d = FROZEN;
    end
  end

  // Class counters ignore the filter but stop counting while IDLE.
  always_comb begin
    cnt_d      = cnt_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;
    if (arm_i) begin
      for (int i = 0; i < 32; i++) cnt_d[i] = '0;
      dropped_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (snap_valid_i && (state_q != IDLE) && (cnt_q[cls] != CNT_MAX)) begin
        cnt_d[cls] = cnt_q[cls] + 1'b1;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (dropped_q != CNT_MAX) dropped_d = dropped_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_valid_o = (fifo_count != '0);
  assign rd_pc_o    = head.pc;
  assign rd_inst_o  = head.inst;
  assign rd_daddr_o = head.daddr;
  assign rd_dwe_o   = head.dwe;
  assign count_o    = fifo_count;
  assign overflow_o = overflow_q;
  assign dropped_o  = dropped_q;
  assign state_o    = state_q;
  assign cnt_o      = cnt_q[cnt_sel_i];

endmodule

// File: doc/hfrv_trace_monitor.md
Name: hfrv_trace_monitor

Overview:
Synthesisable retired-instruction trace monitor for the HF-RISCV core. It captures per-retirement snapshots (PC, instruction word, data address, data write flag) into a circular trace buffer of parametrised depth. Capture supports an optional opcode filter and either wrap-around or stop-when-full mode. It also keeps saturating per-major-opcode retirement counters. It sits beside dut_top and is read out through a valid/ready port by the bench or a debug bridge.

Parameters:
XLEN, 32, width of PC and data address.
DEPTH, 16, trace entries; power of two, at least 2.
CNT_W, 16, width of each opcode class counter.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
snap_valid_i  in  1  one instruction retired this cycle
snap_pc_i  in  XLEN  PC of retired instruction
snap_inst_i  in  32  instruction word
snap_daddr_i  in  XLEN  data address (don't-care for non-memory ops)
snap_dwe_i  in  1  retired instruction wrote memory
arm_i  in  1  pulse: clear buffer and counters, enter CAPTURE
stop_i  in  1  pulse: return to IDLE, buffer contents kept
mode_wrap_i  in  1  1 = overwrite oldest when full, 0 = freeze when full
filter_en_i  in  1  enable opcode filter
filter_opcode_i  in  7  opcode to match against snap_inst_i[6:0]
rd_valid_o  out  1  head entry available
rd_ready_i  in  1  consumer pops head when rd_valid_o and rd_ready_i
rd_pc_o  out  XLEN  head entry PC
rd_inst_o  out  32  head entry instruction
rd_daddr_o  out  XLEN  head entry data address
rd_dwe_o  out  1  head entry write flag
count_o  out  $clog2(DEPTH)+1  entries held
overflow_o  out  1  sticky: at least one entry lost or overwritten
dropped_o  out  CNT_W  saturating count of lost or overwritten entries
state_o  out  2  0 IDLE, 1 CAPTURE, 2 FROZEN
cnt_sel_i  in  5  opcode class select, matched against inst[6:2]
cnt_o  out  CNT_W  counter value for cnt_sel_i, combinational

Behaviour:
- Reset: state IDLE; pointers, count_o, overflow_o, dropped_o and all class counters 0; rd_valid_o 0. rd_* data fields read 0 until the first write. Reset overrides every other input, including during capture.
- FSM:
  - IDLE: arm_i leads to CAPTURE.
  - CAPTURE: stop_i leads to IDLE. A write that makes the buffer full with mode_wrap_i=0 leads to FROZEN.
  - FROZEN: stop_i leads to IDLE; arm_i leads to CAPTURE.
  - arm_i in any state clears the buffer, counters, overflow_o and dropped_o, then enters CAPTURE; snapshots arriving in that same cycle are ignored.
  - arm_i and stop_i together: arm wins.
- Accept: snap_valid_i and state is CAPTURE and (not filter_en_i or inst[6:0]==filter_opcode_i). An accepted entry is visible on rd_* the next cycle (FWFT; rd_valid_o = count_o != 0).
- Class counters: in CAPTURE or FROZEN, every snap_valid_i increments counter[inst[6:2]], ignoring the filter. Counters saturate at 2^CNT_W-1 and do not count in IDLE.
- Pop allowed in every state. Pop on an empty buffer is ignored.
- Simultaneous accept and pop, not full: count unchanged, both pointers advance.
- Full with mode_wrap_i=1, accept and no pop: overwrite oldest, advance the read pointer, count stays DEPTH, set overflow_o, dropped_o +1.
- Full, accept and pop in the same cycle: the entry is popped, the new entry is written, no drop.
- FROZEN: snapshots that would have been accepted increment dropped_o and set overflow_o. Popping does not leave FROZEN.
- Pointers are PTR_W=$clog2(DEPTH) bits and wrap modulo DEPTH. count_o is one bit wider so it can represent DEPTH.

Decomposition:
- Package hfrv_trace_pkg:
  - trace_entry_t struct {pc, inst, daddr, dwe}, parametrised via XLEN localparam.
  - trace_state_e enum (IDLE, CAPTURE, FROZEN).
  - Opcode constants OP_LOAD 7'h03, OP_STORE 7'h23, OP_OPIMM 7'h13, OP_BRANCH 7'h63, OP_JAL 7'h6F.
- Sub-module hfrv_trace_fifo: circular storage, pointers, count, overwrite-on-full.
- The top holds the FSM, filter, class counters and drop statistics.

Test Plan:
- Reset then arm_i; retire 3 ADDI (inst 32'h00100093) at PC 0x100, 0x104, 0x108 -> count_o=3; pops return PCs 0x100, 0x104, 0x108 in order; cnt_o with cnt_sel_i=5'h04 reads 3.
- DEPTH=16, mode_wrap_i=0, retire 20 instructions -> state_o=2 after the 16th; dropped_o=4, overflow_o=1; pops return the first 16 PCs.
- mode_wrap_i=1, retire 20 PCs 0x0..0x4C step 4 -> count_o=16, dropped_o=4; the first pop returns PC 0x10.
- filter_en_i=1, filter_opcode_i=7'h23, mixed stream of 5 SW and 5 LW -> count_o=5, all with rd_dwe_o=1; cnt_o at class 5'h00 = 5 and at class 5'h08 = 5.
- Full buffer in wrap mode with accept and pop in the same cycle -> count_o stays 16, dropped_o unchanged; the popped entry is the oldest.
- reset asserted mid-capture with count_o=7 -> next cycle count_o=0, state_o=0, rd_valid_o=0, and all counters read 0.
